// File: rtl/apd_timer_all.sv
// apd_timer_all: 4-channel photon time-tagger emitting {wrap, delta_mask, strobe_mask, timestamp} records.
// Optional macro DELTA_CHANNELS_EN builds the per-channel level-change (delta) detectors.
module apd_timer_all #(
  parameter int unsigned TIMER_WIDTH    = 38,
  parameter logic [15:0] CTRL_ADDR      = 16'h0003,
  parameter logic [15:0] STROBE_EN_ADDR = 16'h0004,
  parameter logic [15:0] DELTA_EN_ADDR  = 16'h0005
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             strobe_in,
  input  logic [15:0]            reg_addr,
  input  logic [31:0]            reg_data,
  input  logic                   reg_wr,
  output logic                   record_rdy,
  output logic [TIMER_WIDTH+8:0] record
);

  logic [2:0]             r_ctrl;
  logic [3:0]             r_strobe_en;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic                   r_wrap_pend;
  logic [3:0]             r_sync1, r_sync2, r_prev;
  logic                   r_st_vld, r_st_wrap;
  logic [3:0]             r_st_smask, r_st_dmask;
  logic [TIMER_WIDTH-1:0] r_st_ts;

  logic [3:0] w_rise, w_delta;
  logic       w_wrap_step, w_fire, w_unused;

`ifdef DELTA_CHANNELS_EN
  logic [3:0] r_delta_en;
  always_comb begin
    w_delta  = (r_sync2 ^ r_prev) & r_delta_en;
    w_unused = ^reg_data[31:4];
  end
`else
  always_comb begin
    w_delta  = '0;
    w_unused = ^{reg_data[31:4], reg_addr == DELTA_EN_ADDR};
  end
`endif

  // Wrap is flagged in the cycle the timer reads 0 after rolling over, so it lines up with
  // events detected in that same cycle and shares their record.
  always_comb begin
    w_rise      = r_sync2 & ~r_prev & r_strobe_en;
    w_wrap_step = (&r_timer) & r_ctrl[0] & ~r_ctrl[2];
    w_fire      = r_ctrl[1] & ((|w_rise) | (|w_delta) | r_wrap_pend);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl      <= '0;
      r_strobe_en <= '0;
`ifdef DELTA_CHANNELS_EN
      r_delta_en  <= '0;
`endif
      r_timer     <= '0;
      r_wrap_pend <= 1'b0;
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_prev      <= '0;
      r_st_vld    <= 1'b0;
      r_st_wrap   <= 1'b0;
      r_st_smask  <= '0;
      r_st_dmask  <= '0;
      r_st_ts     <= '0;
      record_rdy  <= 1'b0;
      record      <= '0;
    end else begin
      if (reg_wr) begin
        if (reg_addr == CTRL_ADDR)      r_ctrl      <= reg_data[2:0];
        if (reg_addr == STROBE_EN_ADDR) r_strobe_en <= reg_data[3:0];
`ifdef DELTA_CHANNELS_EN
        if (reg_addr == DELTA_EN_ADDR)  r_delta_en  <= reg_data[3:0];
`endif
      end

      if (r_ctrl[2])      r_timer <= '0;
      else if (r_ctrl[0]) r_timer <= r_timer + TIMER_WIDTH'(1);
      r_wrap_pend <= w_wrap_step;

      r_sync1 <= strobe_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;

      // Detection stage captures the timer of the detection cycle; output stage follows.
      r_st_vld <= w_fire;
      if (w_fire) begin
        r_st_wrap  <= r_wrap_pend;
        r_st_dmask <= w_delta;
        r_st_smask <= w_rise;
        r_st_ts    <= r_timer;
      end

      record_rdy <= r_st_vld;
      if (r_st_vld) record <= {r_st_wrap, r_st_dmask, r_st_smask, r_st_ts};
    end
  end

endmodule

// File: tb/tb_apd_timer_all.sv
// Directed self-checking bench for apd_timer_all, built with an 8-bit timer so rollover is reachable.
module tb_apd_timer_all;

  localparam int unsigned TW = 8;
  localparam int unsigned RW = TW + 9;
  localparam logic [15:0] CTRL_A   = 16'h0003;
  localparam logic [15:0] STROBE_A = 16'h0004;
  localparam logic [15:0] DELTA_A  = 16'h0005;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    strobe_in;
  logic [15:0]   reg_addr;
  logic [31:0]   reg_data;
  logic          reg_wr;
  logic          record_rdy;
  logic [RW-1:0] record;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  apd_timer_all #(
    .TIMER_WIDTH   (TW),
    .CTRL_ADDR     (CTRL_A),
    .STROBE_EN_ADDR(STROBE_A),
    .DELTA_EN_ADDR (DELTA_A)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .strobe_in (strobe_in),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data),
    .reg_wr    (reg_wr),
    .record_rdy(record_rdy),
    .record    (record)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // After return, cyc is the edge that sampled the write.
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    reg_addr = a;
    reg_data = d;
    reg_wr   = 1'b1;
    step();
    reg_wr   = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] m);
    strobe_in = strobe_in | m;
    step();
    step();
    strobe_in = strobe_in & ~m;
  endtask

  task automatic wait_rdy(input int unsigned budget, output bit seen,
                          output logic [RW-1:0] rec, output int unsigned at);
    seen = 1'b0;
    rec  = '0;
    at   = 0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      step();
      if (record_rdy === 1'b1) begin
        seen = 1'b1;
        rec  = record;
        at   = cyc;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; strobe_in = '0; reg_addr = '0; reg_data = '0; reg_wr = 1'b0;
    step(); step(); step();
    n_checks++;
    if (record_rdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdy: got %b want 0", record_rdy);
    end
    n_checks++;
    if (record !== '0) begin
      n_fail++; $display("FAIL reset_record: got %h want 0", record);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_strobe();
    bit seen; logic [RW-1:0] rec, exp; int unsigned at, t0, m;
    wr(CTRL_A, 32'd4); wr(CTRL_A, 32'd0); wr(STROBE_A, 32'hF); wr(CTRL_A, 32'd3);
    t0 = cyc; m = cyc;
    pulse(4'b0010);
    wait_rdy(8, seen, rec, at);
    exp = {1'b0, 4'b0000, 4'b0010, TW'(m + 2 - t0)};
    n_checks++;
    if (!seen || rec !== exp) begin
      n_fail++; $display("FAIL single_rec: got %h (seen=%0d) want %h", rec, seen, exp);
    end
    n_checks++;
    if (at !== m + 4) begin
      n_fail++; $display("FAIL single_latency: got cycle %0d want %0d", at, m + 4);
    end
    step();
    n_checks++;
    if (record_rdy !== 1'b0) begin
      n_fail++; $display("FAIL single_pulse_width: got rdy %b want 0", record_rdy);
    end
    n_checks++;
    if (record !== exp) begin
      n_fail++; $display("FAIL single_hold: got %h want %h", record, exp);
    end
  endtask

  task automatic test_simultaneous();
    bit seen; logic [RW-1:0] rec, exp; int unsigned at, t0, m;
    wr(CTRL_A, 32'd4); wr(CTRL_A, 32'd3);
    t0 = cyc;
    step(); step(); step();
    m = cyc;
    pulse(4'b0011);
    wait_rdy(8, seen, rec, at);
    exp = {1'b0, 4'b0000, 4'b0011, TW'(m + 2 - t0)};
    n_checks++;
    if (!seen || rec !== exp || at !== m + 4) begin
      n_fail++; $display("FAIL simul_rec: got %h at %0d (seen=%0d) want %h at %0d", rec, at, seen, exp, m + 4);
    end
  endtask

  task automatic test_channel_enable();
    bit seen; logic [RW-1:0] rec, exp; int unsigned at, t0, m;
    wr(STROBE_A, 32'h1); wr(CTRL_A, 32'd4); wr(CTRL_A, 32'd3);
    t0 = cyc;
    pulse(4'b0100);
    wait_rdy(8, seen, rec, at);
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL disabled_channel: got record %h want none", rec);
    end
    strobe_in[2] = 1'b1;
    step(); step(); step();
    wr(STROBE_A, 32'hF);
    wait_rdy(6, seen, rec, at);
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL enable_while_high: got record %h want none", rec);
    end
    strobe_in[2] = 1'b0;
    step(); step(); step();
    wr(STROBE_A, 32'h1);
    m = cyc;
    pulse(4'b0001);
    wait_rdy(8, seen, rec, at);
    exp = {1'b0, 4'b0000, 4'b0001, TW'(m + 2 - t0)};
    n_checks++;
    if (!seen || rec !== exp) begin
      n_fail++; $display("FAIL enabled_channel: got %h (seen=%0d) want %h", rec, seen, exp);
    end
    wr(STROBE_A, 32'hF);
  endtask

  task automatic test_record_disable();
    bit seen; logic [RW-1:0] rec, exp; int unsigned at, b, c, m;
    wr(CTRL_A, 32'd4); wr(CTRL_A, 32'd1);
    b = cyc;
    pulse(4'b1000);
    wait_rdy(8, seen, rec, at);
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL gen_disabled: got record %h want none", rec);
    end
    wr(CTRL_A, 32'd3);
    m = cyc;
    pulse(4'b0001);
    wait_rdy(8, seen, rec, at);
    exp = {1'b0, 4'b0000, 4'b0001, TW'(m + 2 - b)};
    n_checks++;
    if (!seen || rec !== exp) begin
      n_fail++; $display("FAIL timer_advanced: got %h (seen=%0d) want %h", rec, seen, exp);
    end
    wr(CTRL_A, 32'd7);
    pulse(4'b0010);
    wait_rdy(8, seen, rec, at);
    exp = {1'b0, 4'b0000, 4'b0010, TW'(0)};
    n_checks++;
    if (!seen || rec !== exp) begin
      n_fail++; $display("FAIL rstcnt_dominates: got %h (seen=%0d) want %h", rec, seen, exp);
    end
    wr(CTRL_A, 32'd5);
    step(); step(); step();
    wr(CTRL_A, 32'd3);
    c = cyc; m = cyc;
    pulse(4'b0100);
    wait_rdy(8, seen, rec, at);
    exp = {1'b0, 4'b0000, 4'b0100, TW'(m + 2 - c)};
    n_checks++;
    if (!seen || rec !== exp) begin
      n_fail++; $display("FAIL ctrl5_zero: got %h (seen=%0d) want %h", rec, seen, exp);
    end
  endtask

  task automatic test_back_to_back();
    bit seen; logic [RW-1:0] rec, exp; int unsigned at, t0, m;
    wr(CTRL_A, 32'd4); wr(CTRL_A, 32'd3);
    t0 = cyc;
    wr(16'h0103, 32'd0);
    m = cyc;
    strobe_in[0] = 1'b1; step();
    strobe_in[1] = 1'b1; step();
    strobe_in[0] = 1'b0; step();
    strobe_in[1] = 1'b0;
    wait_rdy(8, seen, rec, at);
    exp = {1'b0, 4'b0000, 4'b0001, TW'(m + 2 - t0)};
    n_checks++;
    if (!seen || rec !== exp || at !== m + 4) begin
      n_fail++; $display("FAIL b2b_first: got %h at %0d (seen=%0d) want %h at %0d", rec, at, seen, exp, m + 4);
    end
    step();
    exp = {1'b0, 4'b0000, 4'b0010, TW'(m + 3 - t0)};
    n_checks++;
    if (record_rdy !== 1'b1 || record !== exp) begin
      n_fail++; $display("FAIL b2b_second: got rdy %b rec %h want rdy 1 rec %h", record_rdy, record, exp);
    end
  endtask

  task automatic test_delta();
    bit seen; logic [RW-1:0] rec; int unsigned at, t0, m;
`ifdef DELTA_CHANNELS_EN
    logic [RW-1:0] exp;
`endif
    wr(STROBE_A, 32'h0); wr(DELTA_A, 32'h8); wr(CTRL_A, 32'd4); wr(CTRL_A, 32'd3);
    t0 = cyc; m = cyc;
    strobe_in[3] = 1'b1;
    wait_rdy(8, seen, rec, at);
`ifdef DELTA_CHANNELS_EN
    exp = {1'b0, 4'b1000, 4'b0000, TW'(m + 2 - t0)};
    n_checks++;
    if (!seen || rec !== exp || at !== m + 4) begin
      n_fail++; $display("FAIL delta_rise: got %h at %0d (seen=%0d) want %h at %0d", rec, at, seen, exp, m + 4);
    end
`else
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL delta_rise_absent: got record %h (t0=%0d m=%0d) want none", rec, t0, m);
    end
`endif
    step(); step();
    m = cyc;
    strobe_in[3] = 1'b0;
    wait_rdy(8, seen, rec, at);
`ifdef DELTA_CHANNELS_EN
    exp = {1'b0, 4'b1000, 4'b0000, TW'(m + 2 - t0)};
    n_checks++;
    if (!seen || rec !== exp || at !== m + 4) begin
      n_fail++; $display("FAIL delta_fall: got %h at %0d (seen=%0d) want %h at %0d", rec, at, seen, exp, m + 4);
    end
`else
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL delta_fall_absent: got record %h want none", rec);
    end
`endif
    wr(DELTA_A, 32'h0); wr(STROBE_A, 32'hF);
  endtask

  task automatic test_reset_midstream();
    bit seen; logic [RW-1:0] rec; int unsigned at;
    wr(CTRL_A, 32'd4); wr(CTRL_A, 32'd3);
    strobe_in[1] = 1'b1;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    strobe_in[1] = 1'b0;
    n_checks++;
    if (record_rdy !== 1'b0 || record !== '0) begin
      n_fail++; $display("FAIL midstream_reset: got rdy %b rec %h want rdy 0 rec 0", record_rdy, record);
    end
    wait_rdy(8, seen, rec, at);
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL pending_discarded: got record %h want none", rec);
    end
  endtask

  task automatic test_wrap();
    bit seen; logic [RW-1:0] rec, exp; int unsigned at, t0;
    wr(STROBE_A, 32'hF); wr(CTRL_A, 32'd4); wr(CTRL_A, 32'd3);
    t0 = cyc;
    wait_rdy(300, seen, rec, at);
    exp = {1'b1, 4'b0000, 4'b0000, TW'(0)};
    n_checks++;
    if (!seen || rec !== exp || at !== t0 + 258) begin
      n_fail++; $display("FAIL wrap_rec: got %h at %0d (seen=%0d) want %h at %0d", rec, at, seen, exp, t0 + 258);
    end
    step();
    n_checks++;
    if (record_rdy !== 1'b0) begin
      n_fail++; $display("FAIL wrap_single: got rdy %b want 0", record_rdy);
    end
    wr(CTRL_A, 32'd4); wr(CTRL_A, 32'd3);
    t0 = cyc;
    while (cyc < t0 + 254) step();
    pulse(4'b0100);
    wait_rdy(8, seen, rec, at);
    exp = {1'b1, 4'b0000, 4'b0100, TW'(0)};
    n_checks++;
    if (!seen || rec !== exp || at !== t0 + 258) begin
      n_fail++; $display("FAIL wrap_shared: got %h at %0d (seen=%0d) want %h at %0d", rec, at, seen, exp, t0 + 258);
    end
    wr(CTRL_A, 32'd0);
  endtask

  initial begin
    test_reset();
    test_single_strobe();
    test_simultaneous();
    test_channel_enable();
    test_record_disable();
    test_back_to_back();
    test_delta();
    test_reset_midstream();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
